// File: rtl/dma64_rr_sched.sv
// dma64_rr_sched
// Round-robin scheduler for a 64:1 single-bit select mux. One requester at a
// time owns the mux select. The owner keeps it for up to MAX_BURST beats,
// until it flags the last beat, or until it drops its request. Priority then
// rotates so that the previous owner becomes the lowest-priority channel.
// Every output comes straight from a register. No input has a combinational
// path to any output.

module dma64_rr_sched #(
  parameter int MAX_BURST = 16,  // beats per grant, 1..256
  parameter int CW        = 8    // beat counter width, 2**CW >= MAX_BURST
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [63:0]   req,
  input  logic          beat,
  input  logic          last,
  output logic [5:0]    sel,
  output logic [63:0]   grant,
  output logic          gnt_valid,
  output logic [CW-1:0] beat_cnt,
  output logic          rel,
  output logic          abort
);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_GRANT = 1'b1
  } state_t;

  localparam logic [CW-1:0] LAST_BEAT_IDX = CW'(MAX_BURST - 1);

  // Registered state
  state_t        r_state;
  logic [5:0]    r_ptr;     // most recent owner; it scans last next time
  logic [5:0]    r_sel;
  logic [63:0]   r_grant;
  logic [CW-1:0] r_cnt;
  logic          r_rel;
  logic          r_abort;

  // Next-state values
  state_t        w_state_nxt;
  logic [5:0]    w_ptr_nxt;
  logic [5:0]    w_sel_nxt;
  logic [63:0]   w_grant_nxt;
  logic [CW-1:0] w_cnt_nxt;
  logic          w_rel_nxt;
  logic          w_abort_nxt;

  // Arbitration
  logic [5:0]    w_start;
  logic [5:0]    w_winner;
  logic          w_any_req;

  // Release decode
  logic          w_own_req;
  logic          w_rel_last;
  logic          w_rel_burst;
  logic          w_rel_drop;
  logic          w_release;
  logic          w_abort_cond;

  assign w_start   = r_ptr + 6'd1;
  assign w_any_req = |req;

  // Rotating priority search: the first set request at or after ptr+1, modulo 64
  always_comb begin
    // NOTE: give every always_comb output a default before any branch. Then
    // no path leaves it unassigned, and synthesis cannot infer a latch.
    w_winner = w_start;
    // The loop runs downward, so the lowest offset is assigned last and wins.
    for (int i = 63; i >= 0; i--) begin
      if (req[w_start + 6'(i)]) begin
        w_winner = w_start + 6'(i);
      end
    end
  end

  // Release conditions for the current owner, checked every GRANT cycle
  always_comb begin
    w_own_req    = req[r_sel];
    w_rel_last   = beat && last;
    w_rel_burst  = beat && (r_cnt == LAST_BEAT_IDX);
    w_rel_drop   = !w_own_req;
    w_release    = w_rel_last || w_rel_burst || w_rel_drop;
    // A beat in the same cycle as the dropped request still counts as a
    // normal completion. So abort needs a drop with no beat at all.
    w_abort_cond = w_rel_drop && !beat;
  end

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      // NOTE: sequential state uses non-blocking assignment. Every register
      // then samples the pre-edge values, whatever the statement order.
      r_state <= w_state_nxt;
    end
  end

  // FSM next-state and next-output logic
  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    w_sel_nxt   = r_sel;
    w_grant_nxt = r_grant;
    w_cnt_nxt   = r_cnt;
    w_rel_nxt   = 1'b0;
    w_abort_nxt = 1'b0;

    case (r_state)
      S_IDLE: begin
        // In IDLE, beat is ignored and sel keeps the most recent owner.
        if (w_any_req) begin
          w_state_nxt = S_GRANT;
          w_sel_nxt   = w_winner;
          w_grant_nxt = 64'd1 << w_winner;
          w_cnt_nxt   = '0;
        end
      end

      S_GRANT: begin
        if (beat) begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
        if (w_release) begin
          w_state_nxt = S_IDLE;
          w_grant_nxt = '0;
          w_ptr_nxt   = r_sel;
          w_cnt_nxt   = '0;
          w_rel_nxt   = 1'b1;
          w_abort_nxt = w_abort_cond;
        end
      end

      default: begin
        w_state_nxt = S_IDLE;
        w_grant_nxt = '0;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // Datapath registers: pointer, select, grant vector, beat count, release flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr   <= 6'd63;  // channel 0 has first priority after reset
      r_sel   <= 6'd0;
      r_grant <= '0;
      r_cnt   <= '0;
      r_rel   <= 1'b0;
      r_abort <= 1'b0;
    end else begin
      r_ptr   <= w_ptr_nxt;
      r_sel   <= w_sel_nxt;
      r_grant <= w_grant_nxt;
      r_cnt   <= w_cnt_nxt;
      r_rel   <= w_rel_nxt;
      r_abort <= w_abort_nxt;
    end
  end

  assign sel       = r_sel;
  assign grant     = r_grant;
  assign gnt_valid = (r_state == S_GRANT);
  assign beat_cnt  = r_cnt;
  assign rel       = r_rel;
  assign abort     = r_abort;

endmodule

// File: tb/tb_dma64_rr_sched.sv
// Directed testbench for dma64_rr_sched (MAX_BURST=16, CW=8).
// Each status comparison uses the bundle {gnt_valid, rel, abort, sel, beat_cnt}.

module tb_dma64_rr_sched;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] req;
  logic        beat;
  logic        last;
  logic [5:0]  sel;
  logic [63:0] grant;
  logic        gnt_valid;
  logic [7:0]  beat_cnt;
  logic        rel;
  logic        abort;

  int n_pass  = 0;
  int n_total = 0;

  logic [16:0] obs;
  logic [16:0] exp_st;
  logic [63:0] exp_g;

  assign obs = {gnt_valid, rel, abort, sel, beat_cnt};

  always #5 clk = ~clk;

  dma64_rr_sched #(.MAX_BURST(16), .CW(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .beat      (beat),
    .last      (last),
    .sel       (sel),
    .grant     (grant),
    .gnt_valid (gnt_valid),
    .beat_cnt  (beat_cnt),
    .rel       (rel),
    .abort     (abort)
  );

  // Advance one clock. Outputs are sampled and inputs driven 1 ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst  = 1'b1;
    req  = '0;
    beat = 1'b0;
    last = 1'b0;
    #12;
    exp_st = 17'd0;
    if (obs !== exp_st) $display("FAIL reset_status: got %h want %h", obs, exp_st);
    else n_pass++;
    n_total++;
    if (grant !== 64'd0) $display("FAIL reset_grant: got %h want %h", grant, 64'd0);
    else n_pass++;
    n_total++;
    @(negedge clk);
    rst = 1'b0;
    step();
  endtask

  task automatic test_spurious_beat();
    req  = '0;
    beat = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      exp_st = 17'd0;
      if (obs !== exp_st || grant !== 64'd0)
        $display("FAIL spurious[%0d]: got %h/%h want %h/0", i, obs, grant, exp_st);
      else n_pass++;
      n_total++;
    end
    beat = 1'b0;
  endtask

  task automatic test_rotation();
    logic [5:0] e;
    req = '1;
    for (int k = 0; k <= 64; k++) begin
      e = 6'(k % 64);
      step();
      exp_st = {1'b1, 1'b0, 1'b0, e, 8'd0};
      exp_g  = 64'd1 << e;
      if (obs !== exp_st || grant !== exp_g)
        $display("FAIL rot_grant[%0d]: got %h/%h want %h/%h", k, obs, grant, exp_st, exp_g);
      else n_pass++;
      n_total++;
      beat = 1'b1;
      last = 1'b1;
      step();
      exp_st = {1'b0, 1'b1, 1'b0, e, 8'd0};
      if (obs !== exp_st || grant !== 64'd0)
        $display("FAIL rot_rel[%0d]: got %h/%h want %h/0", k, obs, grant, exp_st);
      else n_pass++;
      n_total++;
      beat = 1'b0;
      last = 1'b0;
      if (k == 64) req = '0;
    end
    step();
    exp_st = {1'b0, 1'b0, 1'b0, 6'd0, 8'd0};
    if (obs !== exp_st) $display("FAIL rot_idle: got %h want %h", obs, exp_st);
    else n_pass++;
    n_total++;
  endtask

  task automatic test_burst_limit();
    req = 64'd1 << 7;
    step();
    exp_st = {1'b1, 1'b0, 1'b0, 6'd7, 8'd0};
    if (obs !== exp_st) $display("FAIL burst_grant: got %h want %h", obs, exp_st);
    else n_pass++;
    n_total++;
    beat = 1'b1;
    for (int b = 1; b <= 15; b++) begin
      step();
      exp_st = {1'b1, 1'b0, 1'b0, 6'd7, 8'(b)};
      if (obs !== exp_st) $display("FAIL burst_cnt[%0d]: got %h want %h", b, obs, exp_st);
      else n_pass++;
      n_total++;
    end
    step();
    exp_st = {1'b0, 1'b1, 1'b0, 6'd7, 8'd0};
    if (obs !== exp_st) $display("FAIL burst_rel: got %h want %h", obs, exp_st);
    else n_pass++;
    n_total++;
    beat = 1'b0;
    step();
    exp_st = {1'b1, 1'b0, 1'b0, 6'd7, 8'd0};
    if (obs !== exp_st) $display("FAIL burst_regrant: got %h want %h", obs, exp_st);
    else n_pass++;
    n_total++;
    beat = 1'b1;
    last = 1'b1;
    step();
    exp_st = {1'b0, 1'b1, 1'b0, 6'd7, 8'd0};
    if (obs !== exp_st) $display("FAIL burst_last_rel: got %h want %h", obs, exp_st);
    else n_pass++;
    n_total++;
    beat = 1'b0;
    last = 1'b0;
    req  = '0;
    step();
    exp_st = {1'b0, 1'b0, 1'b0, 6'd7, 8'd0};
    if (obs !== exp_st) $display("FAIL burst_idle: got %h want %h", obs, exp_st);
    else n_pass++;
    n_total++;
  endtask

  task automatic test_wrap_around();
    req = 64'd1 << 62;
    step();
    exp_st = {1'b1, 1'b0, 1'b0, 6'd62, 8'd0};
    if (obs !== exp_st) $display("FAIL wrap_g62: got %h want %h", obs, exp_st);
    else n_pass++;
    n_total++;
    beat = 1'b1;
    last = 1'b1;
    step();
    beat = 1'b0;
    last = 1'b0;
    req  = (64'd1 << 62) | (64'd1 << 2);
    step();
    exp_st = {1'b1, 1'b0, 1'b0, 6'd2, 8'd0};
    if (obs !== exp_st || grant !== 64'd4)
      $display("FAIL wrap_g2: got %h/%h want %h/4", obs, grant, exp_st);
    else n_pass++;
    n_total++;
    beat = 1'b1;
    last = 1'b1;
    step();
    exp_st = {1'b0, 1'b1, 1'b0, 6'd2, 8'd0};
    if (obs !== exp_st) $display("FAIL wrap_rel2: got %h want %h", obs, exp_st);
    else n_pass++;
    n_total++;
    beat = 1'b0;
    last = 1'b0;
    step();
    exp_st = {1'b1, 1'b0, 1'b0, 6'd62, 8'd0};
    if (obs !== exp_st) $display("FAIL wrap_g62b: got %h want %h", obs, exp_st);
    else n_pass++;
    n_total++;
    beat = 1'b1;
    last = 1'b1;
    step();
    beat = 1'b0;
    last = 1'b0;
    req  = '0;
    step();
  endtask

  task automatic test_abort();
    req = 64'd1 << 40;
    step();
    exp_st = {1'b1, 1'b0, 1'b0, 6'd40, 8'd0};
    if (obs !== exp_st) $display("FAIL abort_grant: got %h want %h", obs, exp_st);
    else n_pass++;
    n_total++;
    // Another channel raises its request mid-grant; the owner must keep the grant.
    req = (64'd1 << 40) | (64'd1 << 3);
    step();
    if (obs !== exp_st) $display("FAIL abort_other_req: got %h want %h", obs, exp_st);
    else n_pass++;
    n_total++;
    req = '0;
    step();
    exp_st = {1'b0, 1'b1, 1'b1, 6'd40, 8'd0};
    if (obs !== exp_st) $display("FAIL abort_rel: got %h want %h", obs, exp_st);
    else n_pass++;
    n_total++;
    step();
    exp_st = {1'b0, 1'b0, 1'b0, 6'd40, 8'd0};
    if (obs !== exp_st) $display("FAIL abort_pulse: got %h want %h", obs, exp_st);
    else n_pass++;
    n_total++;
    req = 64'd1 << 40;
    step();
    beat = 1'b1;
    step();
    exp_st = {1'b1, 1'b0, 1'b0, 6'd40, 8'd1};
    if (obs !== exp_st) $display("FAIL abort_beat1: got %h want %h", obs, exp_st);
    else n_pass++;
    n_total++;
    req = '0;
    step();
    exp_st = {1'b0, 1'b1, 1'b0, 6'd40, 8'd0};
    if (obs !== exp_st) $display("FAIL drop_with_beat: got %h want %h", obs, exp_st);
    else n_pass++;
    n_total++;
    beat = 1'b0;
    step();
  endtask

  task automatic test_reset_mid_grant();
    req = 64'd1 << 5;
    step();
    beat = 1'b1;
    repeat (3) step();
    exp_st = {1'b1, 1'b0, 1'b0, 6'd5, 8'd3};
    if (obs !== exp_st) $display("FAIL midrst_pre: got %h want %h", obs, exp_st);
    else n_pass++;
    n_total++;
    beat = 1'b0;
    rst  = 1'b1;
    #1;
    if (obs !== 17'd0 || grant !== 64'd0)
      $display("FAIL midrst_async: got %h/%h want 0/0", obs, grant);
    else n_pass++;
    n_total++;
    req = (64'd1 << 5) | 64'd1;
    step();
    rst = 1'b0;
    step();
    exp_st = {1'b1, 1'b0, 1'b0, 6'd0, 8'd0};
    if (obs !== exp_st || grant !== 64'd1)
      $display("FAIL midrst_ch0: got %h/%h want %h/1", obs, grant, exp_st);
    else n_pass++;
    n_total++;
    beat = 1'b1;
    last = 1'b1;
    step();
    beat = 1'b0;
    last = 1'b0;
    req  = '0;
    step();
  endtask

  initial begin
    test_reset();
    test_spurious_beat();
    test_rotation();
    test_burst_limit();
    test_wrap_around();
    test_abort();
    test_reset_mid_grant();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/dma64_rr_sched.md
# dma64_rr_sched

Round-robin scheduler that shares the 64:1 single-bit select mux in the BASIC_DMA64 library among 64 requesting channels. It picks one requester and drives the mux `sel` together with a one-hot grant. It holds that grant for a bounded burst of beats, then releases it and rotates priority. It sits between the per-channel request logic and the mux select input, so the mux datapath itself stays purely combinational.

## Interface
- MAX_BURST, 16, maximum beats per grant; legal range 1..256.
- CW, 8, beat counter width; must satisfy 2^CW >= MAX_BURST.
- clk  input  1  sole clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- req  input  64  per-channel request; bit i drives mux input i.
- beat  input  1  one beat consumed through the mux this cycle; ignored unless gnt_valid=1.
- last  input  1  qualifies beat as the final beat of the owner's transfer.
- sel  output  6  mux select; index of the current or most recent owner.
- grant  output  64  one-hot grant, bit sel; all zero when gnt_valid=0.
- gnt_valid  output  1  a grant is active.
- beat_cnt  output  CW  beats taken in the current grant.
- rel  output  1  one-cycle pulse in the cycle after a grant ends.
- abort  output  1  valid with rel; 1 when the grant ended because the owner dropped req.

## Operation
- States: IDLE, GRANT. Internal priority pointer ptr (6 bits).
- Reset values: state=IDLE, ptr=63 (channel 0 is first priority), sel=0, grant=0, gnt_valid=0, beat_cnt=0, rel=0, abort=0.
- IDLE, req==0: stay in IDLE; sel holds its previous value; grant=0.
- IDLE, req!=0: the winner is the first set bit found scanning ptr+1, ptr+2, … modulo 64. On the next clock:
  - sel=winner, grant=1<<winner, gnt_valid=1, beat_cnt=0, state=GRANT.
- GRANT: a beat is counted when beat=1, incrementing beat_cnt.
- GRANT release conditions, checked every cycle. Release occurs when any of these holds:
  - (a) beat && last;
  - (b) beat && beat_cnt==MAX_BURST-1;
  - (c) !req[sel].
- On release, at the next clock:
  - state=IDLE, gnt_valid=0, grant=0, ptr=sel, beat_cnt=0, rel=1.
  - abort=1 only when (c) holds and neither (a) nor (b) holds.
- Simultaneous events:
  - If beat=1 and req[sel]=0 in the same cycle, the beat still counts and the grant releases with abort=0.
  - Any of (a), (b) or (c) releases in the same cycle.
- The winner is not re-granted before other pending requesters. ptr=sel makes it lowest priority for the next arbitration.
- With MAX_BURST=1, every beat releases the grant.
- Changes to req bits other than req[sel] have no effect during GRANT.

## Timing
- Arbitration latency: req is sampled in an IDLE cycle t, and gnt_valid/sel/grant are registered high at t+1.
- sel is stable for the whole GRANT period. The mux output is valid combinationally in every GRANT cycle.
- Release latency: the release condition in cycle t gives gnt_valid=0 and rel=1 at t+1. The next arbitration samples req at t+1, and the next grant appears at t+2.
- Minimum gap between grants is one IDLE cycle. Maximum grant length is MAX_BURST beats, or unbounded cycles if beat stays 0 and req stays high.
- All outputs are registered; no combinational path from inputs to outputs.
- rst asserted mid-grant returns every output to its reset value immediately (asynchronous). The first grant after reset favours channel 0.

## Test plan
- Reset mid-grant: owner 5 with beat_cnt=3, assert rst -> sel=0, grant=0, gnt_valid=0, beat_cnt=0 immediately; after release, req[0] and req[5] both high -> channel 0 granted.
- Rotation: req=64'hFFFF_FFFF_FFFF_FFFF, each owner sends beat+last on its first grant cycle -> sel sequence 0,1,2,…,63,0; rel pulses each time with abort=0; one IDLE cycle between grants.
- Burst limit: MAX_BURST=16, req[7] held, beat=1 continuously, last=0 -> release after 16 beats; beat_cnt reaches 15; rel=1, abort=0; the next grant goes to the next requester above 7, or back to 7 if it is the only requester.
- Wrap-around: ptr=62 after granting channel 62, req bits 2 and 62 set -> grant goes to channel 2; then with req[62] still high, grant goes to 62.
- Abort: owner 40 drops req[40] with beat=0 -> gnt_valid falls next cycle with rel=1, abort=1. Repeat with beat=1 and req[40]=0 in the same cycle -> beat counted, abort=0.
- Spurious beat: beat=1 in IDLE with req=0 -> beat_cnt stays 0, no grant, no rel.
